i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//   I2S master transmitter. The audio path's other direction: the soc_system audio
//   component receives mic samples over I2S. This block drives a DAC/codec from
//   stereo samples that an upstream Avalon-side writer pushes over a valid/ready port.
//   It generates SCK/WS/SD from the system clock in Philips I2S format.
// PARAMETERS
//   DATA_W   24  sample width per channel; MSB-first, two's complement
//   SLOT_W   32  SCK bits per channel slot (SLOT_W >= DATA_W+1); LSBs padded with 0
//   CLK_DIV  8   clk cycles per SCK half-period (>=1); SCK = clk/(2*CLK_DIV)
// PORTS
//   clk         in   1       system clock (50 MHz)
//   reset_n     in   1       asynchronous active-low reset
//   en          in   1       1 = run; 0 = finish current frame, then idle
//   s_valid     in   1       sample pair valid
//   s_ready     out  1       holding register empty; transfer when s_valid & s_ready
//   s_left      in   DATA_W  left sample (WS low slot)
//   s_right     in   DATA_W  right sample (WS high slot)
//   i2s_sck     out  1       bit clock
//   i2s_ws      out  1       word select (0 = left)
//   i2s_sd      out  1       serial data; changes on SCK falling edge
//   underrun    out  1       1-clk pulse: frame started with no sample held
//   busy        out  1       state != IDLE
// BEHAVIOUR
//   Reset: i2s_sck=0, i2s_ws=1, i2s_sd=0, s_ready=1, underrun=0, busy=0, all counters 0.
//   Buffering: a holding register (hold) plus a 2*SLOT_W shift register. s_ready = !hold_valid, registered.
//   A sample is accepted on the clk edge with s_valid & s_ready and is held until the next frame load.
//   Divider: div_cnt counts 0..CLK_DIV-1 in RUN/DRAIN. At CLK_DIV-1 it wraps and SCK toggles.
//   A toggle 1->0 is a "fall". All WS/SD updates occur in the same clk as a fall.
//   bit_cnt (0..2*SLOT_W-1) increments at every fall and wraps to 0 (frame boundary).
//   WS = 0 for bit_cnt 0..SLOT_W-1 and 1 for SLOT_W..2*SLOT_W-1.
//   SD lags WS by one SCK: the left MSB is on SD while bit_cnt==1, the right MSB while bit_cnt==SLOT_W+1.
//   Frame load happens at the fall where bit_cnt becomes 0:
//     - hold_valid: shift <= {left,pad,right,pad}, hold_valid <= 0.
//     - hold empty: shift <= 0 and underrun pulses for 1 clk.
//   A sample accepted in that same clk stays in hold for the following frame.
//   At bit_cnt==0, SD still carries the last pad bit of the right slot (0).
//   States:
//     IDLE : SCK=0, WS=1, SD=0, counters held at 0. en=1 -> RUN. First fall -> bit_cnt=0 and frame load.
//     RUN  : en=0 -> DRAIN.
//     DRAIN: continues until the fall where bit_cnt wraps to 0. There: no load, SD=0, WS=1 -> IDLE.
//            en=1 in DRAIN -> RUN with no glitch.
//   s_valid/s_ready accepts in all states. In IDLE the hold is retained.
//   Async reset mid-frame: outputs go to reset values immediately and the hold contents are discarded.
// CONFIGURATION
//   I2S_TX_MUTE_EN defined:
//     - Adds input `mute` (1 bit).
//     - mute is sampled only at the frame load. If 1, shift <= 0 but the held sample is still consumed
//       (no underrun).
//     - Mute therefore applies on whole-frame boundaries only.
//   I2S_TX_MUTE_EN undefined: no mute port, no mute logic.
// TESTING
//   1. CLK_DIV=2, SLOT_W=32, DATA_W=24.
//      Push L=24'h800001, R=24'h7FFFFE, en=1.
//      -> SD left slot = 1000_0000_0000_0000_0000_0001 then 8x0.
//      -> Right slot = 0111...1110 then 8x0.
//      -> SCK period = 4 clk; WS edges 128 clk apart.
//   2. Back-to-back source with s_valid held high.
//      -> Exactly one accept per frame (every 256 clk at CLK_DIV=2), underrun never asserts.
//      -> s_ready falls 1 clk after each accept.
//   3. en=1 with no samples.
//      -> SD constant 0, one underrun pulse per frame.
//      -> Push one sample mid-frame -> it is transmitted in the next frame only.
//   4. Deassert en at bit_cnt=5.
//      -> Current frame completes; SCK stops low, WS=1 at the wrap; busy=0 one clk later.
//      -> Reasserting en during DRAIN -> continuous frames, no gap.
//   5. Assert reset_n=0 mid-right-slot.
//      -> SCK=0, WS=1, SD=0, s_ready=1 asynchronously.
//      -> After release with en=1, the first frame is zeros plus underrun.
//   6. (I2S_TX_MUTE_EN) mute=1 at a frame load with a sample held.
//      -> SD all 0, s_ready rises, no underrun.
//      -> mute toggled mid-frame has no effect until the next load.

Source files
------------

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: stereo sample stream from the upstream writer into i2s_tx.
// Ports: s_valid/s_left/s_right from source, s_ready back from the transmitter.
interface i2s_tx_if #(
   parameter int DATA_W = 24
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_left;
   logic [DATA_W-1:0] s_right;

   modport master (
      output s_valid,
      output s_left,
      output s_right,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_left,
      input  s_right,
      output s_ready
   );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S master transmitter (SCK/WS/SD from clk).
// Ports: clk, reset_n (async low), en, s (i2s_tx_if.slave sample stream),
//   i2s_sck, i2s_ws, i2s_sd, underrun (1-clk pulse), busy (state != IDLE).
// Build option: I2S_TX_MUTE_EN adds input mute, sampled at each frame load.
module i2s_tx #(
   parameter int DATA_W  = 24,
   parameter int SLOT_W  = 32,
   parameter int CLK_DIV = 8
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     en,
`ifdef I2S_TX_MUTE_EN
   input  logic     mute,
`endif
   i2s_tx_if.slave  s,
   output logic     i2s_sck,
   output logic     i2s_ws,
   output logic     i2s_sd,
   output logic     underrun,
   output logic     busy
);

   localparam int FRM_W = 2 * SLOT_W;
   localparam int PAD_W = SLOT_W - DATA_W;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(FRM_W);

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(FRM_W - 1);
   localparam logic [BIT_W-1:0] WS_START = BIT_W'(SLOT_W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t state_q, state_d;

   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              first_q, first_d;
   logic              sck_q, sck_d;
   logic              ws_q, ws_d;
   logic              sd_q, sd_d;
   logic              ur_q, ur_d;
   logic [FRM_W-1:0]  shift_q, shift_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0] hold_l_q, hold_l_d;
   logic [DATA_W-1:0] hold_r_q, hold_r_d;

   logic             run;
   logic             draining;
   logic             tick;
   logic             fall;
   logic             wrap;
   logic             stop;
   logic             load;
   logic             acc;
   logic [FRM_W-1:0] frame_w;

   // ---------------- FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs
   always_comb begin
      run      = (state_q != IDLE);
      draining = (state_q == DRAIN);
      busy     = run;
   end

   // first_q marks the frame's opening fall after IDLE, which loads
   // without having counted through a previous frame.
   assign tick = run & (div_q == DIV_MAX);
   assign fall = tick & sck_q;
   assign wrap = fall & (first_q | (bit_q == BIT_MAX));
   assign stop = wrap & draining & ~en;
   assign load = wrap & ~stop;

   assign acc     = s.s_valid & ~hold_valid_q;
   assign frame_w = {hold_l_q, {PAD_W{1'b0}},
                     hold_r_q, {PAD_W{1'b0}}};

   // ---------------- divider / serialiser
   always_comb begin
      div_d   = div_q;
      bit_d   = bit_q;
      first_d = first_q;
      sck_d   = sck_q;
      ws_d    = ws_q;
      sd_d    = sd_q;
      shift_d = shift_q;
      ur_d    = 1'b0;
      if (!run) begin
         div_d   = '0;
         bit_d   = '0;
         first_d = 1'b1;
         sck_d   = 1'b0;
         ws_d    = 1'b1;
         sd_d    = 1'b0;
      end else if (tick) begin
         div_d = '0;
         sck_d = ~sck_q;
         if (fall) begin
            first_d = 1'b0;
            if (stop) begin
               bit_d   = '0;
               first_d = 1'b1;
               ws_d    = 1'b1;
               sd_d    = 1'b0;
               shift_d = '0;
            end else begin
               bit_d = wrap ? '0 : bit_q + 1'b1;
               ws_d  = (bit_d >= WS_START);
               // SD trails WS by one SCK: emit the bit shifted out last
               sd_d  = shift_q[FRM_W-1];
               if (load) begin
                  if (!hold_valid_q) begin
                     shift_d = '0;
                     ur_d    = 1'b1;
                  end else begin
`ifdef I2S_TX_MUTE_EN
                     shift_d = mute ? '0 : frame_w;
`else
                     shift_d = frame_w;
`endif
                  end
               end else begin
                  shift_d = {shift_q[FRM_W-2:0], 1'b0};
               end
            end
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   // ---------------- holding register
   // A load and an accept never both touch hold in one clk with data:
   // accept needs hold empty, consume needs hold full.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_l_d     = hold_l_q;
      hold_r_d     = hold_r_q;
      if (load && hold_valid_q) begin
         hold_valid_d = 1'b0;
      end
      if (acc) begin
         hold_valid_d = 1'b1;
         hold_l_d     = s.s_left;
         hold_r_d     = s.s_right;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q        <= '0;
         bit_q        <= '0;
         first_q      <= 1'b1;
         sck_q        <= 1'b0;
         ws_q         <= 1'b1;
         sd_q         <= 1'b0;
         ur_q         <= 1'b0;
         shift_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_l_q     <= '0;
         hold_r_q     <= '0;
      end else begin
         div_q        <= div_d;
         bit_q        <= bit_d;
         first_q      <= first_d;
         sck_q        <= sck_d;
         ws_q         <= ws_d;
         sd_q         <= sd_d;
         ur_q         <= ur_d;
         shift_q      <= shift_d;
         hold_valid_q <= hold_valid_d;
         hold_l_q     <= hold_l_d;
         hold_r_q     <= hold_r_d;
      end
   end

   assign s.s_ready = ~hold_valid_q;
   assign i2s_sck   = sck_q;
   assign i2s_ws    = ws_q;
   assign i2s_sd    = sd_q;
   assign underrun  = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: random stimulus for i2s_tx, queue scoreboard decoding the
// I2S pins back into sample pairs and checking underrun/s_ready/timing.
module tb_i2s_tx;

   localparam int DW  = 24;
   localparam int SW  = 32;
   localparam int CD  = 2;
   localparam int FW  = 2 * SW;
   localparam int FRM_CLK = FW * 2 * CD;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic en = 1'b0;
`ifdef I2S_TX_MUTE_EN
   logic mute = 1'b0;
`endif
   logic sck, ws, sd, underrun, busy;

   i2s_tx_if #(.DATA_W(DW)) sif ();

   i2s_tx #(
      .DATA_W (DW),
      .SLOT_W (SW),
      .CLK_DIV(CD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
`ifdef I2S_TX_MUTE_EN
      .mute    (mute),
`endif
      .s       (sif.slave),
      .i2s_sck (sck),
      .i2s_ws  (ws),
      .i2s_sd  (sd),
      .underrun(underrun),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic fail(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- reference model
   logic [2*DW-1:0] sq[$];
   logic            pend = 1'b0;
   logic [2*DW-1:0] pend_s;
   logic [2*DW-1:0] mon_s;
   logic            prev_ws = 1'b1;
   logic            prev_sck = 1'b0;
   logic            mute_prev = 1'b0;
   logic            exp_ur;
   logic            in_frame = 1'b0;
   logic            have_load = 1'b0;
   logic            idle_since = 1'b1;
   logic [FW-1:0]   exp_frame, rx_sd, rx_ws;
   int              mon_k = 0;
   int              loads = 0;
   int              idle_cycles = 0;
   int              cyc = 0;
   int              last_rise = 0;
   int              last_load = 0;

   // Word on the wire: left MSB-first, zero pad, right, zero pad.
   function automatic logic [FW-1:0] mk_frame(logic [2*DW-1:0] p);
      return {p[2*DW-1:DW], {(SW-DW){1'b0}},
              p[DW-1:0], {(SW-DW){1'b0}}};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         sq.delete();
         pend      = 1'b0;
         prev_ws   = 1'b1;
         prev_sck  = 1'b0;
         in_frame  = 1'b0;
         have_load = 1'b0;
         mon_k     = 0;
      end else begin
         exp_ur = 1'b0;
         if (!busy) begin
            idle_since = 1'b1;
            idle_cycles++;
         end
         // WS only falls at a frame start
         if (prev_ws && !ws) begin
            loads++;
            if (have_load && !idle_since)
               chk("frame_period", cyc - last_load, FRM_CLK);
            have_load  = 1'b1;
            idle_since = 1'b0;
            last_load  = cyc;
            if (sq.size() > 0) begin
               mon_s = sq.pop_front();
               exp_frame = mute_prev ? '0 : mk_frame(mon_s);
            end else begin
               exp_frame = '0;
               exp_ur    = 1'b1;
            end
            in_frame = 1'b1;
            mon_k    = 0;
         end
         if (pend) sq.push_back(pend_s);
         chk("underrun", underrun, exp_ur);
         chk("s_ready", sif.s_ready, sq.size() == 0);
         pend   = sif.s_valid & sif.s_ready;
         pend_s = {sif.s_left, sif.s_right};
         if (sck && !prev_sck && in_frame) begin
            if (mon_k > 0) chk("sck_period", cyc - last_rise, 2 * CD);
            last_rise = cyc;
            rx_sd[FW-1-mon_k] = sd;
            rx_ws[FW-1-mon_k] = ws;
            mon_k++;
            if (mon_k == FW) begin
               chk("frame_sd", rx_sd, exp_frame >> 1);
               chk("frame_ws", rx_ws, {{SW{1'b0}}, {SW{1'b1}}});
               in_frame = 1'b0;
            end
         end
         prev_ws  = ws;
         prev_sck = sck;
      end
`ifdef I2S_TX_MUTE_EN
      mute_prev = mute;
`endif
   end

   // ---------------- stimulus helpers
   task automatic wait_clk(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(logic [DW-1:0] l, logic [DW-1:0] r, bit keep);
      sif.s_valid = 1'b1;
      sif.s_left  = l;
      sif.s_right = r;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sif.s_ready) begin
            @(posedge clk);
            #1;
            if (!keep) sif.s_valid = 1'b0;
            return;
         end
      end
      sif.s_valid = 1'b0;
      fail("push");
   endtask

   task automatic wait_k(int k, int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (in_frame && mon_k == k) return;
      end
      fail("wait_k");
   endtask

   task automatic wait_loads(int n, int lim);
      int target;
      target = loads + n;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (loads >= target) return;
      end
      fail("wait_loads");
   endtask

   task automatic wait_idle(int lim);
      for (int i = 0; i < lim; i++) begin
         @(posedge clk);
         #1;
         if (!busy) return;
      end
      fail("wait_idle");
   endtask

   int snap;

   initial begin
      sif.s_valid = 1'b0;
      sif.s_left  = '0;
      sif.s_right = '0;
      #12;
      chk("rst_sck", sck, 1'b0);
      chk("rst_ws", ws, 1'b1);
      chk("rst_sd", sd, 1'b0);
      chk("rst_ready", sif.s_ready, 1'b1);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_clk(2);

      // known pattern, then empty frame
      push(24'h800001, 24'h7FFFFE, 1'b0);
      en = 1'b1;
      wait_loads(2, 1200);

      // back-to-back source
      for (int i = 0; i < 6; i++)
         push(DW'($urandom), DW'($urandom), 1'b1);
      sif.s_valid = 1'b0;
      wait_loads(2, 1200);

      // starved, then one sample mid-frame
      wait_loads(2, 1200);
      wait_k(20, 600);
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_loads(2, 1200);

      // drain at bit 5
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_k(5, 600);
      en = 1'b0;
      wait_idle(600);
      chk("drain_sck", sck, 1'b0);
      chk("drain_ws", ws, 1'b1);
      chk("drain_sd", sd, 1'b0);
      chk("drain_complete", mon_k, FW);

      // re-enable during drain: no gap
      en = 1'b1;
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_k(5, 600);
      en = 1'b0;
      wait_k(40, 600);
      en = 1'b1;
      snap = idle_cycles;
      wait_loads(2, 1200);
      chk("no_gap", idle_cycles, snap);

      // reset mid right slot with a sample held
      wait_k(30, 600);
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_k(40, 600);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_sck", sck, 1'b0);
      chk("arst_ws", ws, 1'b1);
      chk("arst_sd", sd, 1'b0);
      chk("arst_ready", sif.s_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_loads(2, 1200);

`ifdef I2S_TX_MUTE_EN
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_k(60, 600);
      mute = 1'b1;
      wait_loads(1, 600);
      push(DW'($urandom), DW'($urandom), 1'b0);
      wait_k(10, 600);
      mute = 1'b0;
      wait_loads(2, 1200);
`endif

      // random traffic and enable toggling
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6 && (en || sif.s_ready))
            push(DW'($urandom), DW'($urandom), 1'b0);
         else if (r == 6)
            en = 1'b0;
         else
            en = 1'b1;
         wait_clk($urandom_range(1, 300));
      end

      en = 1'b0;
      wait_idle(1200);
      wait_clk(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
